// File: rtl/video_st_source.sv
// Avalon-ST video test-pattern source: streams WIDTH x HEIGHT frames of a selectable
// pattern, with an idle gap between frames and a completed-frame counter.
module video_st_source #(
    parameter int          WIDTH       = 320,
    parameter int          HEIGHT      = 240,
    parameter int          FRAME_GAP   = 16,
    parameter logic [23:0] SOLID_COLOR = 24'h0000FF
) (
    input  logic        pixel_clk_clk,
    input  logic        pixel_reset_reset,
    input  logic        enable,
    input  logic [1:0]  pattern,
    output logic [23:0] src_data,
    output logic        src_startofpacket,
    output logic        src_endofpacket,
    output logic        src_valid,
    input  logic        src_ready,
    output logic [15:0] frame_count,
    output logic        busy
);

    // state  | meaning
    // IDLE   | no frame in progress, waiting for enable
    // ACTIVE | presenting beats of the current frame
    // GAP    | FRAME_GAP idle cycles after a frame's last beat
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP
    } state_t;

    localparam logic [11:0] X_LAST   = 12'(WIDTH - 1);
    localparam logic [11:0] Y_LAST   = 12'(HEIGHT - 1);
    localparam logic [8:0]  BAR_LOAD = 9'((WIDTH / 8) - 1);
    localparam logic [15:0] GAP_LOAD = 16'((FRAME_GAP > 0) ? (FRAME_GAP - 1) : 0);
    localparam bit          HAS_GAP  = (FRAME_GAP > 0);

    state_t      state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [1:0]  pat_q, pat_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [8:0]  bar_cnt_q, bar_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [23:0] data_q, data_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    logic        xfer;
    logic        start_frame;
    logic        advance;
    logic        goto_gap;
    logic        goto_idle;
    logic [11:0] nx;
    logic [11:0] ny;
    logic [2:0]  nbar;
    logic [8:0]  ncnt;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Only the low byte of x and bit 4 of y ever influence the pixel value.
    function automatic logic [23:0] pixel(input logic [1:0] pat, input logic [7:0] xl,
                                          input logic y4, input logic [2:0] bar);
        logic [23:0] p;
        case (pat)
            2'd0:    p = SOLID_COLOR;
            2'd1:    p = bar_color(bar);
            2'd2:    p = {xl, xl, xl};
            default: p = (xl[4] ^ y4) ? 24'hFFFFFF : 24'h000000;
        endcase
        return p;
    endfunction

    assign xfer = valid_q & src_ready;

    // Next raster position and bar tracking for the beat after the current one.
    always_comb begin
        nx   = x_q + 12'd1;
        ny   = y_q;
        nbar = bar_idx_q;
        ncnt = bar_cnt_q - 9'd1;
        if (x_q == X_LAST) begin
            nx   = 12'd0;
            ny   = y_q + 12'd1;
            nbar = 3'd0;
            ncnt = BAR_LOAD;
        end else if (bar_cnt_q == 9'd0) begin
            nbar = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
            ncnt = BAR_LOAD;
        end
    end

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        pat_d         = pat_q;
        bar_idx_d     = bar_idx_q;
        bar_cnt_d     = bar_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        frame_count_d = frame_count_q;
        data_d        = data_q;
        sop_d         = sop_q;
        eop_d         = eop_q;
        valid_d       = valid_q;
        busy_d        = busy_q;
        start_frame   = 1'b0;
        advance       = 1'b0;
        goto_gap      = 1'b0;
        goto_idle     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) start_frame = 1'b1;
            end
            S_ACTIVE: begin
                if (xfer) begin
                    if (eop_q) begin
                        frame_count_d = frame_count_q + 16'd1;
                        if (HAS_GAP)     goto_gap    = 1'b1;
                        else if (enable) start_frame = 1'b1;
                        else             goto_idle   = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 16'd0) begin
                    if (enable) start_frame = 1'b1;
                    else        goto_idle   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: goto_idle = 1'b1;
        endcase

        if (start_frame) begin
            state_d   = S_ACTIVE;
            pat_d     = pattern;
            x_d       = 12'd0;
            y_d       = 12'd0;
            bar_idx_d = 3'd0;
            bar_cnt_d = BAR_LOAD;
            data_d    = pixel(pattern, 8'd0, 1'b0, 3'd0);
            sop_d     = 1'b1;
            eop_d     = 1'b0;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
        end
        if (advance) begin
            x_d       = nx;
            y_d       = ny;
            bar_idx_d = nbar;
            bar_cnt_d = ncnt;
            data_d    = pixel(pat_q, nx[7:0], ny[4], nbar);
            sop_d     = 1'b0;
            eop_d     = (nx == X_LAST) && (ny == Y_LAST);
        end
        if (goto_gap) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
            sop_d     = 1'b0;
            eop_d     = 1'b0;
            valid_d   = 1'b0;
            busy_d    = 1'b1;
        end
        if (goto_idle) begin
            state_d   = S_IDLE;
            sop_d     = 1'b0;
            eop_d     = 1'b0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
        end
    end

    always_ff @(posedge pixel_clk_clk) begin
        if (pixel_reset_reset) begin
            state_q       <= S_IDLE;
            x_q           <= 12'd0;
            y_q           <= 12'd0;
            pat_q         <= 2'd0;
            bar_idx_q     <= 3'd0;
            bar_cnt_q     <= 9'd0;
            gap_cnt_q     <= 16'd0;
            frame_count_q <= 16'd0;
            data_q        <= 24'd0;
            sop_q         <= 1'b0;
            eop_q         <= 1'b0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pat_q         <= pat_d;
            bar_idx_q     <= bar_idx_d;
            bar_cnt_q     <= bar_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_count_q <= frame_count_d;
            data_q        <= data_d;
            sop_q         <= sop_d;
            eop_q         <= eop_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
        end
    end

    assign src_data          = data_q;
    assign src_startofpacket = sop_q;
    assign src_endofpacket   = eop_q;
    assign src_valid         = valid_q;
    assign frame_count       = frame_count_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_video_st_source.sv
// Bench for video_st_source: two instances (small frame with gap, wide frame without gap)
// driven by shared stimulus; beats are checked against a raster/pattern reference model.
module tb_video_st_source;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [1:0]  pat;
    logic        sel;

    logic [23:0] data_a, data_b;
    logic        sop_a, sop_b, eop_a, eop_b, valid_a, valid_b, busy_a, busy_b;
    logic [15:0] fc_a, fc_b;

    logic [23:0] o_data;
    logic        o_sop, o_eop, o_valid, o_busy;
    logic [15:0] o_fc;

    int total = 0;
    int bad   = 0;

    video_st_source #(.WIDTH(8), .HEIGHT(4), .FRAME_GAP(2), .SOLID_COLOR(24'h0000FF)) dut_a (
        .pixel_clk_clk(clk), .pixel_reset_reset(rst), .enable(en), .pattern(pat),
        .src_data(data_a), .src_startofpacket(sop_a), .src_endofpacket(eop_a),
        .src_valid(valid_a), .src_ready(rdy), .frame_count(fc_a), .busy(busy_a)
    );

    video_st_source #(.WIDTH(300), .HEIGHT(2), .FRAME_GAP(0), .SOLID_COLOR(24'h0000FF)) dut_b (
        .pixel_clk_clk(clk), .pixel_reset_reset(rst), .enable(en), .pattern(pat),
        .src_data(data_b), .src_startofpacket(sop_b), .src_endofpacket(eop_b),
        .src_valid(valid_b), .src_ready(rdy), .frame_count(fc_b), .busy(busy_b)
    );

    assign o_data  = sel ? data_b  : data_a;
    assign o_sop   = sel ? sop_b   : sop_a;
    assign o_eop   = sel ? eop_b   : eop_a;
    assign o_valid = sel ? valid_b : valid_a;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_fc    = sel ? fc_b    : fc_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // Expected pixel straight from the pattern definitions.
    function automatic logic [23:0] exp_pix(input int p, input int x, input int y, input int w);
        int bar;
        int xl;
        if (p == 0) return 24'h0000FF;
        if (p == 2) begin
            xl = x % 256;
            return {xl[7:0], xl[7:0], xl[7:0]};
        end
        if (p == 3) return ((((x / 16) + (y / 16)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
        bar = x / (w / 8);
        if (bar > 7) bar = 7;
        case (bar)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Runs one full frame of the selected instance; returns just after the EOP transfer edge.
    task automatic stream(input int ready_pct, input int drop_at, input int chg_at,
                          input logic [1:0] chg_pat, input int fpat);
        int w, h, n, k;
        bit started;
        bit took;
        logic [23:0] want;
        w = sel ? 300 : 8;
        h = sel ? 2 : 4;
        n = w * h;
        k = 0;
        started = 0;
        for (int cyc = 0; cyc < 4 * n + 50 && k < n; cyc++) begin
            rdy = ($urandom_range(0, 99) < ready_pct);
            if (k == drop_at) en = 1'b0;
            if (k == chg_at) pat = chg_pat;
            if (o_valid === 1'b1) started = 1;
            if (started) begin
                total++;
                want = exp_pix(fpat, k % w, k / w, w);
                if (o_valid !== 1'b1 || o_data !== want || o_sop !== (k == 0) || o_eop !== (k == n - 1)) begin
                    bad++;
                    $display("FAIL beat %0d: valid=%b data=%h sop=%b eop=%b, want valid=1 data=%h sop=%b eop=%b",
                             k, o_valid, o_data, o_sop, o_eop, want, (k == 0), (k == n - 1));
                end
            end
            took = (o_valid === 1'b1) && rdy;
            tick();
            if (took) k++;
        end
        total++;
        if (k != n) begin
            bad++;
            $display("FAIL frame_timeout: beats=%0d want %0d", k, n);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        en  = 1'b1;
        rdy = 1'b1;
        pat = 2'd1;
        tick();
        tick();
        total++;
        if ({valid_a, sop_a, eop_a, busy_a, valid_b, sop_b, eop_b, busy_b} !== 8'd0 ||
            data_a !== 24'd0 || data_b !== 24'd0 || fc_a !== 16'd0 || fc_b !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: a v/s/e/b=%b%b%b%b d=%h fc=%0d b v/s/e/b=%b%b%b%b d=%h fc=%0d want all 0",
                     valid_a, sop_a, eop_a, busy_a, data_a, fc_a, valid_b, sop_b, eop_b, busy_b, data_b, fc_b);
        end
        rst = 1'b0;
        en  = 1'b0;
        tick();
    endtask

    task automatic test_bars();
        sel = 1'b0;
        do_reset();
        pat = 2'd1;
        en  = 1'b1;
        stream(100, -1, -1, 2'd0, 1);
        total++;
        if (o_fc !== 16'd1 || o_valid !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL bars_gap1: fc=%0d valid=%b busy=%b want 1 0 1", o_fc, o_valid, o_busy);
        end
        tick();
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL bars_gap2: valid=%b want 0", o_valid);
        end
        tick();
        total++;
        if (o_valid !== 1'b1 || o_sop !== 1'b1 || o_data !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL bars_next_frame: valid=%b sop=%b data=%h want 1 1 ffffff", o_valid, o_sop, o_data);
        end
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        do_reset();
        pat = 2'd1;
        en  = 1'b1;
        stream(50, -1, -1, 2'd0, 1);
        total++;
        if (o_fc !== 16'd1) begin
            bad++;
            $display("FAIL bp_frame_count: fc=%0d want 1", o_fc);
        end
    endtask

    task automatic test_enable_drop();
        sel = 1'b0;
        do_reset();
        pat = 2'd1;
        en  = 1'b1;
        stream(100, 10, -1, 2'd0, 1);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_fc !== 16'd1) begin
            bad++;
            $display("FAIL enable_drop_idle: valid=%b busy=%b fc=%0d want 0 0 1", o_valid, o_busy, o_fc);
        end
    endtask

    task automatic test_reset_midframe();
        int k;
        bit seen;
        sel = 1'b0;
        do_reset();
        pat = 2'd1;
        en  = 1'b1;
        k = 0;
        for (int c = 0; c < 60; c++) begin
            if (o_valid === 1'b1) begin
                if (k == 17) break;
                k++;
            end
            tick();
        end
        total++;
        if (k != 17) begin
            bad++;
            $display("FAIL midreset_reach: beats=%0d want 17", k);
        end
        rst = 1'b1;
        tick();
        total++;
        if (o_valid !== 1'b0 || o_fc !== 16'd0 || o_busy !== 1'b0 || o_eop !== 1'b0) begin
            bad++;
            $display("FAIL midreset_abort: valid=%b fc=%0d busy=%b eop=%b want 0 0 0 0", o_valid, o_fc, o_busy, o_eop);
        end
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin
            tick();
            if (o_valid === 1'b1) seen = 1;
        end
        total++;
        if (!seen || o_sop !== 1'b1 || o_data !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL midreset_restart: valid=%b sop=%b data=%h want 1 1 ffffff", o_valid, o_sop, o_data);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        do_reset();
        pat = 2'd2;
        en  = 1'b1;
        stream(100, -1, -1, 2'd0, 2);
        total++;
        if (o_fc !== 16'd1 || o_valid !== 1'b1 || o_sop !== 1'b1 || o_data !== 24'h000000) begin
            bad++;
            $display("FAIL b2b_next_sop: fc=%0d valid=%b sop=%b data=%h want 1 1 1 000000", o_fc, o_valid, o_sop, o_data);
        end
    endtask

    task automatic test_pattern_change();
        sel = 1'b1;
        do_reset();
        pat = 2'd0;
        en  = 1'b1;
        stream(100, -1, 5, 2'd3, 0);
        rdy = 1'b1;
        total++;
        if (o_valid !== 1'b1 || o_sop !== 1'b1 || o_data !== 24'h000000) begin
            bad++;
            $display("FAIL patchg_origin: valid=%b sop=%b data=%h want 1 1 000000", o_valid, o_sop, o_data);
        end
        for (int i = 0; i < 16; i++) tick();
        total++;
        if (o_valid !== 1'b1 || o_sop !== 1'b0 || o_data !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL patchg_x16: valid=%b sop=%b data=%h want 1 0 ffffff", o_valid, o_sop, o_data);
        end
        en = 1'b0;
    endtask

    task automatic test_random_frames();
        int p;
        sel = 1'b0;
        for (int f = 0; f < 6; f++) begin
            do_reset();
            p   = $urandom_range(0, 3);
            pat = 2'(p);
            en  = 1'b1;
            stream(30 + $urandom_range(0, 70), -1, $urandom_range(1, 30), 2'($urandom_range(0, 3)), p);
            total++;
            if (o_fc !== 16'd1) begin
                bad++;
                $display("FAIL random_frame_count: frame %0d fc=%0d want 1", f, o_fc);
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        rst = 1'b1;
        en  = 1'b0;
        rdy = 1'b0;
        pat = 2'd0;
        test_reset();
        test_bars();
        test_backpressure();
        test_enable_drop();
        test_reset_midframe();
        test_back_to_back();
        test_pattern_change();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_st_source.md
VIDEO_ST_SOURCE -- requirements
Module: video_st_source

Interface
REQ-001 SHALL have parameter WIDTH, default 320: active pixels per line, range 8..4095.
REQ-002 SHALL have parameter HEIGHT, default 240: lines per frame, range 1..4095.
REQ-003 SHALL have parameter FRAME_GAP, default 16: idle cycles between frames, range 0..65535.
REQ-004 SHALL have parameter SOLID_COLOR, default 24'h0000FF: pixel value for pattern 0.
REQ-005 SHALL have port pixel_clk_clk  in  1: sole clock, all logic rising-edge.
REQ-006 SHALL have port pixel_reset_reset  in  1: synchronous, active-high reset.
REQ-007 SHALL have port enable  in  1: 1 = generate frames continuously.
REQ-008 SHALL have port pattern  in  2: 0 solid, 1 colour bars, 2 gradient, 3 checkerboard.
REQ-009 SHALL have port src_data  out  24: pixel {R[23:16],G[15:8],B[7:0]}.
REQ-010 SHALL have ports src_startofpacket, src_endofpacket, src_valid  out  1 each: Avalon-ST source qualifiers.
REQ-011 SHALL have port src_ready  in  1: sink ready, readyLatency 0.
REQ-012 SHALL have port frame_count  out  16: completed frames, wraps 65535->0.
REQ-013 SHALL have port busy  out  1: 1 in ACTIVE or GAP.

Function
REQ-014 SHALL implement FSM states IDLE, ACTIVE, GAP; all outputs registered.
REQ-015 SHALL transfer a beat exactly on a cycle with src_valid=1 and src_ready=1; no other cycle advances position.
REQ-016 SHALL hold src_data, src_startofpacket, src_endofpacket unchanged while src_valid=1 and src_ready=0.
REQ-017 IDLE: src_valid=0; enable=1 -> ACTIVE next cycle with x=0, y=0, pattern latched.
REQ-018 ACTIVE: src_valid=1 continuously, including cycles with src_ready=0.
REQ-019 On transfer, x increments; at x=WIDTH-1 x wraps to 0 and y increments.
REQ-020 src_startofpacket SHALL be 1 only on beat (x=0,y=0); src_endofpacket 1 only on beat (WIDTH-1,HEIGHT-1); both set together never.
REQ-021 On EOP transfer: frame_count increments same cycle; state -> GAP if FRAME_GAP>0, else ACTIVE (enable=1) or IDLE (enable=0).
REQ-022 GAP: src_valid=0 for exactly FRAME_GAP cycles, then ACTIVE (enable=1) or IDLE (enable=0).
REQ-023 enable deassert in ACTIVE SHALL NOT truncate a frame; frame completes with EOP, then GAP/IDLE.
REQ-024 pattern SHALL be sampled only on entry to ACTIVE; mid-frame changes apply next frame.
REQ-025 Pattern 1: BAR_W = WIDTH/8 (floor, elaboration constant); bar index increments every BAR_W pixels, saturating at 7; colours in order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-026 Pattern 2: R=G=B=x[7:0] (wraps every 256 pixels).
REQ-027 Pattern 3: src_data = FFFFFF when x[4] XOR y[4] = 1, else 000000.
REQ-028 Pixel data SHALL correspond to the beat's (x,y) on the cycle presented, no offset after backpressure.

Reset
REQ-029 pixel_reset_reset=1 SHALL, next edge, force IDLE, x=y=0, src_valid=0, src_startofpacket=0, src_endofpacket=0, src_data=0, frame_count=0, busy=0.
REQ-030 Reset mid-frame SHALL abort the packet without EOP; after release, the next frame starts with SOP at (0,0).
REQ-031 Reset SHALL dominate enable and src_ready on the same cycle.

Verification
REQ-032 WIDTH=8, HEIGHT=4, FRAME_GAP=2, src_ready=1, enable=1, pattern=1 -> 32 beats: SOP beat 0, EOP beat 31, each line FFFFFF,FFFF00,00FFFF,00FF00,FF00FF,FF0000,0000FF,000000; then exactly 2 valid=0 cycles; frame_count=1.
REQ-033 Same config, src_ready random 50% -> 32 transfers, data/SOP/EOP stable on every stalled cycle, sequence identical to REQ-032.
REQ-034 enable dropped at beat 10 -> remaining 22 beats delivered, EOP, then IDLE, busy=0, frame_count=1.
REQ-035 Reset asserted at beat 17 -> valid=0 next cycle, frame_count=0; after release with enable=1 first beat has SOP, data FFFFFF.
REQ-036 WIDTH=300, HEIGHT=2, FRAME_GAP=0, pattern=2 -> beat x=256 data 000000, x=299 data 2B2B2B; frame 2 SOP on cycle immediately after frame 1 EOP.
REQ-037 pattern changed 0->3 mid-frame -> current frame all 0000FF; next frame (0,0)=000000, (16,0)=FFFFFF.
